// File: rtl/prog_loader.sv
// Byte-serial program loader: assembles a framed byte stream into 16-bit words for instruction memory.
// Define LOADER_CHECKSUM_EN to require and verify a trailing XOR checksum byte.
module prog_loader #(
    parameter int WORD_SIZE   = 16,
    parameter int MEMORY_SIZE = 32,
    parameter int ADDR_W      = $clog2(MEMORY_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset_cpu,
    input  logic                 start,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_error
);

    // One extra bit so the word count can hold MEMORY_SIZE itself.
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     n_q, n_d;
    logic [CNT_W-1:0]     cnt_inc;
    logic [7:0]           hi_q, hi_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                 accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           acc_q, acc_d;
`endif

    always_comb begin
        in_ready   = (state_q != S_DONE) && (state_q != S_ERR);
        cpu_hold   = (state_q != S_DONE);
        load_done  = (state_q == S_DONE);
        load_error = (state_q == S_ERR);
    end

    assign accept    = in_valid && in_ready;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        hi_d        = hi_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        acc_d       = acc_q;
`endif
        unique case (state_q)
            S_IDLE: if (accept) begin
                if (in_data == 8'd0 || int'(in_data) > MEMORY_SIZE) begin
                    state_d = S_ERR;
                end else begin
                    n_d     = CNT_W'(in_data);
                    cnt_d   = '0;
                    state_d = S_HI;
`ifdef LOADER_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            S_HI: if (accept) begin
                hi_d    = in_data;
                state_d = S_LO;
`ifdef LOADER_CHECKSUM_EN
                acc_d   = acc_q ^ in_data;
`endif
            end
            S_LO: if (accept) begin
                // The write is registered, so the strobe appears the cycle after the lo byte.
                mem_we_d    = 1'b1;
                mem_addr_d  = cnt_q[ADDR_W-1:0];
                mem_wdata_d = {hi_q, in_data};
                cnt_d       = cnt_inc;
`ifdef LOADER_CHECKSUM_EN
                acc_d       = acc_q ^ in_data;
                state_d     = (cnt_inc == n_q) ? S_CHK : S_HI;
`else
                state_d     = (cnt_inc == n_q) ? S_DONE : S_HI;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (accept) begin
                state_d = (in_data == acc_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: if (start) begin
                state_d    = S_IDLE;
                mem_addr_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_cpu) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            hi_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            hi_q        <= hi_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame-level reference model, per-cycle compare, directed and random frames.
module tb_prog_loader;

    localparam int MEM = 32;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_cpu, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_hold, load_done, load_error;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;

    int errors = 0;
    int checks = 0;

    prog_loader dut (
        .clk        (clk),
        .reset_cpu  (reset_cpu),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is byte 0 = N, bytes 1..2N = data, byte 2N+1 = checksum.
    typedef enum {M_LOAD, M_DONE, M_ERR} mstat_e;
    mstat_e      m_stat = M_LOAD;
    int          m_k = 0;
    int          m_n = 0;
    logic [7:0]  m_xor = '0;
    logic [7:0]  m_prev = '0;
    logic        exp_we = 1'b0;
    logic [4:0]  exp_addr = '0;
    logic [15:0] exp_wdata = '0;
    logic [15:0] model_mem [MEM];
    logic [15:0] dut_mem [MEM];
    bit          model_live = 1'b0;
    logic [20:0] wlog [$];

    always @(posedge clk) begin
        exp_we = 1'b0;
        if (reset_cpu) begin
            m_stat = M_LOAD; m_k = 0; exp_addr = '0; exp_wdata = '0; model_live = 1'b1;
        end else if (m_stat != M_LOAD) begin
            if (start) begin m_stat = M_LOAD; m_k = 0; exp_addr = '0; end
        end else if (in_valid) begin
            if (m_k == 0) begin
                if (in_data == 0 || in_data > MEM) m_stat = M_ERR;
                else begin m_n = int'(in_data); m_k = 1; m_xor = '0; end
            end else if (m_k <= 2 * m_n) begin
                m_xor ^= in_data;
                if (m_k % 2 == 0) begin
                    exp_we    = 1'b1;
                    exp_addr  = 5'(m_k / 2 - 1);
                    exp_wdata = {m_prev, in_data};
                    model_mem[exp_addr] = exp_wdata;
                end
                m_prev = in_data;
                if (m_k == 2 * m_n && !CHK_EN) m_stat = M_DONE;
                else m_k++;
            end else begin
                m_stat = (in_data == m_xor) ? M_DONE : M_ERR;
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("in_ready", in_ready, m_stat == M_LOAD);
            check("cpu_hold", cpu_hold, m_stat != M_DONE);
            check("load_done", load_done, m_stat == M_DONE);
            check("load_error", load_error, m_stat == M_ERR);
            check("mem_we", mem_we, exp_we);
            if (exp_we) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (mem_we === 1'b1) begin
                wlog.push_back({mem_addr, mem_wdata});
                dut_mem[mem_addr] = mem_wdata;
            end
        end
    end

    logic [7:0] frame_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_checksum(input bit corrupt);
        logic [7:0] x;
        x = '0;
        for (int i = 1; i < frame_q.size(); i++) x ^= frame_q[i];
        if (CHK_EN) frame_q.push_back(corrupt ? ~x : x);
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        frame_q = {};
        frame_q.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) frame_q.push_back(8'($urandom));
        push_checksum(corrupt);
    endtask

    // gap: 0 back-to-back, 1 every other cycle, 2 random gaps with ignored start pulses
    task automatic send_frame(input int gap);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i > 0 && gap > 0) begin
                int idles;
                idles = (gap == 1) ? 1 : int'($urandom_range(0, 2));
                for (int j = 0; j < idles; j++) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    start    = (gap == 2) && ($urandom_range(0, 7) == 0);
                    tick();
                end
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = frame_q[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int base;
        for (int i = 0; i < MEM; i++) begin model_mem[i] = '0; dut_mem[i] = '0; end
        reset_cpu = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        tick(); tick();
        check("rst in_ready", in_ready, 1);
        check("rst mem_we", mem_we, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst cpu_hold", cpu_hold, 1);
        check("rst load_done", load_done, 0);
        check("rst load_error", load_error, 0);
        reset_cpu = 1'b0;
        idle(1);

        // 1: two-word image
        frame_q = {8'h02, 8'h60, 8'h00, 8'h61, 8'h01};
        push_checksum(1'b0);
        base = wlog.size();
        send_frame(0);
        idle(2);
        check("t1 writes", wlog.size() - base, 2);
        check("t1 w0", wlog[base], {5'd0, 16'h6000});
        check("t1 w1", wlog[base+1], {5'd1, 16'h6101});
        check("t1 load_done", load_done, 1);
        check("t1 cpu_hold", cpu_hold, 0);

        // 2: bad headers 00 and 21
        foreach (frame_q[i]) frame_q[i] = '0;
        for (int h = 0; h < 2; h++) begin
            pulse_start();
            frame_q = {(h == 0) ? 8'h00 : 8'h21};
            base = wlog.size();
            send_frame(0);
            idle(2);
            check("t2 load_error", load_error, 1);
            check("t2 in_ready", in_ready, 0);
            check("t2 no write", wlog.size() - base, 0);
            pulse_start();
            check("t2 error cleared", load_error, 0);
            check("t2 idle ready", in_ready, 1);
        end

        // 3: checksum F0^1C = EC, 00 sent instead
        frame_q = {8'h01, 8'hF0, 8'h1C, 8'h00};
        base = wlog.size();
        send_frame(0);
        idle(2);
        check("t3 word", wlog[base], {5'd0, 16'hF01C});
        check("t3 load_error", load_error, CHK_EN);
        check("t3 cpu_hold", cpu_hold, CHK_EN);

        // 4: 28 words with in_valid every other cycle
        pulse_start();
        build_frame(28, 1'b0);
        base = wlog.size();
        send_frame(1);
        idle(2);
        check("t4 pulses", wlog.size() - base, 28);
        for (int i = 0; i < 28; i++) check("t4 addr order", 32'(wlog[base+i][20:16]), i);
        check("t4 load_done", load_done, 1);

        // 5: reset after hi byte of word 3, then a fresh one-word frame
        pulse_start();
        frame_q = {8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send_frame(0);
        reset_cpu = 1'b1;
        tick();
        reset_cpu = 1'b0;
        check("t5 in_ready", in_ready, 1);
        check("t5 mem_addr", mem_addr, 0);
        check("t5 cpu_hold", cpu_hold, 1);
        frame_q = {8'h01, 8'hAB, 8'hCD};
        push_checksum(1'b0);
        base = wlog.size();
        send_frame(0);
        idle(2);
        check("t5 word", wlog[base], {5'd0, 16'hABCD});
        check("t5 load_done", load_done, 1);

        // 6: bytes in DONE dropped; start with a byte in the same cycle drops the byte
        base = wlog.size();
        for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = 8'h01; tick(); end
        idle(2);
        check("t6 no write", wlog.size() - base, 0);
        check("t6 still done", load_done, 1);
        in_valid = 1'b1; in_data = 8'h01; start = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check("t6 cpu_hold", cpu_hold, 1);
        check("t6 in_ready", in_ready, 1);
        check("t6 mem_addr", mem_addr, 0);
        check("t6 load_done", load_done, 0);

        // random frames
        for (int f = 0; f < 40; f++) begin
            pulse_start();
            if ($urandom_range(0, 9) == 0) begin
                frame_q = {($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255))};
            end else begin
                build_frame(int'($urandom_range(1, MEM)), $urandom_range(0, 4) == 0);
            end
            send_frame(int'($urandom_range(0, 2)));
            idle(2);
        end

        for (int i = 0; i < MEM; i++) check("final memory", dut_mem[i], model_mem[i]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
